game_controller: RTL and testbench

Run-state sequencer for the snake game. Paces snake movement with a score-dependent move timer and samples the collision detector once per move. It converts raw, possibly multi-cycle hit levels into single-cycle goodColl/badColl pulses for score_tracker. It also handles start/pause buttons and ends the game on a bad hit or on max score.

---
 rtl/game_controller.sv | 134 +++++++++++++
 tb/tb_game_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// Run-state sequencer for the snake game: paces moves with a score-dependent timer,
// samples collisions once per move and turns hit levels into single-cycle score pulses.
module game_controller #(
  parameter int unsigned BASE_PERIOD = 16,
  parameter int unsigned MIN_PERIOD  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       startBtn,
  input  logic       pauseBtn,
  input  logic       appleHit,
  input  logic       wallHit,
  input  logic       selfHit,
  input  logic [6:0] currScore,
  input  logic       isGameComplete,
  output logic [2:0] gameState,
  output logic       stepEn,
  output logic       goodColl,
  output logic       badColl,
  output logic       appleReq
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRun   = 3'd1,
    StPause = 3'd2,
    StOver  = 3'd3,
    StWin   = 3'd4
  } state_e;

  localparam logic [15:0] BasePeriod = 16'(BASE_PERIOD);
  localparam logic [15:0] MinPeriod  = 16'(MIN_PERIOD);

  state_e      state_q, state_d;
  logic        start_q, pause_q;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] period_q, period_d;
  logic        step_q, step_d;
  logic        good_q, good_d;
  logic        bad_q, bad_d;
  logic        apple_q, apple_d;

  logic               start_edge, pause_edge;
  logic [6:0]         score_div;
  logic signed [16:0] period_raw;
  logic [15:0]        next_period;

  assign start_edge = startBtn & ~start_q;
  assign pause_edge = pauseBtn & ~pause_q;

  // Signed so a large score drives the raw period negative and clamps to the floor.
  always_comb begin
    score_div   = currScore >> 2;
    period_raw  = $signed({1'b0, BasePeriod}) - $signed({10'd0, score_div});
    next_period = (period_raw < $signed({1'b0, MinPeriod})) ? MinPeriod : period_raw[15:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    step_d   = 1'b0;
    good_d   = 1'b0;
    bad_d    = 1'b0;
    apple_d  = 1'b0;
    case (state_q)
      StIdle, StOver, StWin: begin
        if (start_edge) begin
          state_d  = StRun;
          cnt_d    = '0;
          period_d = next_period;
        end
      end
      StRun: begin
        if (isGameComplete) begin
          state_d = StWin;
        end else if (step_q && (wallHit || selfHit)) begin
          state_d = StOver;
          bad_d   = 1'b1;
        end else begin
          if (step_q && appleHit) begin
            good_d  = 1'b1;
            apple_d = 1'b1;
          end
          // The timer only advances on edges that stay in RUN, so pause freezes it exactly.
          if (pause_edge) begin
            state_d = StPause;
          end else if (cnt_q == period_q - 16'd1) begin
            step_d   = 1'b1;
            cnt_d    = '0;
            period_d = next_period;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      StPause: begin
        if (pause_edge) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      start_q  <= 1'b1;
      pause_q  <= 1'b1;
      cnt_q    <= '0;
      period_q <= BasePeriod;
      step_q   <= 1'b0;
      good_q   <= 1'b0;
      bad_q    <= 1'b0;
      apple_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= startBtn;
      pause_q  <= pauseBtn;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      step_q   <= step_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      apple_q  <= apple_d;
    end
  end

  assign gameState = state_q;
  assign stepEn    = step_q;
  assign goodColl  = good_q;
  assign badColl   = bad_q;
  assign appleReq  = apple_q;

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: stimulus queues timed strobe events,
// a negedge monitor pops and compares them whenever a strobe appears.
module tb_game_controller;

  logic       tb_clk = 1'b0;
  logic       rst, startBtn, pauseBtn, appleHit, wallHit, selfHit, isGameComplete;
  logic [6:0] currScore;
  logic [2:0] gameState;
  logic       stepEn, goodColl, badColl, appleReq;

  game_controller #(
    .BASE_PERIOD(16),
    .MIN_PERIOD (4)
  ) dut (
    .clk           (tb_clk),
    .rst           (rst),
    .startBtn      (startBtn),
    .pauseBtn      (pauseBtn),
    .appleHit      (appleHit),
    .wallHit       (wallHit),
    .selfHit       (selfHit),
    .currScore     (currScore),
    .isGameComplete(isGameComplete),
    .gameState     (gameState),
    .stepEn        (stepEn),
    .goodColl      (goodColl),
    .badColl       (badColl),
    .appleReq      (appleReq)
  );

  always #5 tb_clk = ~tb_clk;

  typedef struct {
    int         cyc;
    logic [3:0] str;
    logic [2:0] st;
  } ev_t;

  localparam logic [3:0] Step = 4'b1000;
  localparam logic [3:0] Good = 4'b0101;
  localparam logic [3:0] Bad  = 4'b0010;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_vec = 0;
  int  n_err = 0;
  int  k, k2, k3;

  always @(posedge tb_clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input int c, input logic [3:0] s, input logic [2:0] st);
    ev_t e;
    e.cyc = c;
    e.str = s;
    e.st  = st;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic do_start(output int edge_cyc);
    startBtn = 1'b1;
    edge_cyc = cyc + 1;
    tick();
    startBtn = 1'b0;
  endtask

  // Monitor: strobes {stepEn, goodColl, badColl, appleReq} must match queued events in order.
  always @(negedge tb_clk) begin
    logic [3:0] s;
    ev_t        e;
    s = {stepEn, goodColl, badColl, appleReq};
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missed_event: nothing seen, expected strobes %b at cycle %0d", e.str, e.cyc);
    end
    if (s != 4'b0000) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: got %b at cycle %0d, expected none", s, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.str != s || e.st != gameState) begin
          n_err++;
          $display("FAIL strobe_event: got %b state %0d at cycle %0d, expected %b state %0d at %0d",
                   s, gameState, cyc, e.str, e.st, e.cyc);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missed_event: got 0000, expected strobes %b at cycle %0d", e.str, e.cyc);
    end
  end

  initial begin
    rst = 1'b1; startBtn = 1'b1; pauseBtn = 1'b0; appleHit = 1'b0; wallHit = 1'b0;
    selfHit = 1'b0; currScore = 7'd0; isGameComplete = 1'b0;
    repeat (3) tick();
    check("reset_state", int'(gameState), 0);
    check("reset_strobes", int'({stepEn, goodColl, badColl, appleReq}), 0);
    rst = 1'b0;

    // Start held through reset must not count.
    repeat (5) tick();
    check("held_start_idle", int'(gameState), 0);
    startBtn = 1'b0;
    repeat (2) tick();

    // Default speed, then apple held 40 cycles, then wall+apple together.
    do_start(k);
    check("start_run", int'(gameState), 1);
    for (int i = 1; i <= 6; i++) push(k + 16 * i, Step, 3'd1);
    push(k + 97, Good, 3'd1);
    push(k + 112, Step, 3'd1);
    push(k + 113, Good, 3'd1);
    push(k + 128, Step, 3'd1);
    push(k + 129, Good, 3'd1);
    push(k + 144, Step, 3'd1);
    push(k + 145, Bad, 3'd3);

    run_to(k + 96);
    appleHit = 1'b1;
    repeat (40) tick();
    appleHit = 1'b0;
    check("apple_stays_run", int'(gameState), 1);

    run_to(k + 140);
    wallHit  = 1'b1;
    appleHit = 1'b1;
    run_to(k + 145);
    check("wall_over", int'(gameState), 3);
    wallHit  = 1'b0;
    appleHit = 1'b0;
    run_to(k + 150);
    check("over_holds", int'(gameState), 3);

    // Restart, speed-up to period 11, pause at counter 5, clamp to 4, then win.
    do_start(k2);
    check("restart_run", int'(gameState), 1);
    currScore = 7'd20;
    push(k2 + 16, Step, 3'd1);
    push(k2 + 27, Step, 3'd1);
    push(k2 + 38, Step, 3'd1);
    push(k2 + 80, Step, 3'd1);
    push(k2 + 91, Step, 3'd1);
    push(k2 + 95, Step, 3'd1);
    push(k2 + 99, Step, 3'd1);
    push(k2 + 103, Step, 3'd1);

    run_to(k2 + 43);
    pauseBtn = 1'b1;
    tick();
    pauseBtn = 1'b0;
    check("pause_entered", int'(gameState), 2);
    run_to(k2 + 60);
    startBtn = 1'b1;
    tick();
    startBtn = 1'b0;
    check("start_ignored_in_pause", int'(gameState), 2);
    run_to(k2 + 73);
    pauseBtn = 1'b1;
    tick();
    pauseBtn = 1'b0;
    check("pause_resume", int'(gameState), 1);

    run_to(k2 + 81);
    currScore = 7'd127;
    run_to(k2 + 104);
    isGameComplete = 1'b1;
    tick();
    check("win_state", int'(gameState), 4);
    run_to(k2 + 115);
    isGameComplete = 1'b0;
    check("win_holds", int'(gameState), 4);

    // Reset mid-RUN on the edge that would raise stepEn.
    do_start(k3);
    check("start_from_win", int'(gameState), 1);
    push(k3 + 4, Step, 3'd1);
    run_to(k3 + 7);
    rst = 1'b1;
    tick();
    check("midrun_reset_state", int'(gameState), 0);
    check("midrun_reset_strobes", int'({stepEn, goodColl, badColl, appleReq}), 0);
    rst = 1'b0;
    repeat (10) tick();
    check("idle_after_reset", int'(gameState), 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
